// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial shifter and its receive-side deserializer.
//   P2S_WIDTH  : default word width used by both ends of the serial link.
//   rx_state_t : receiver FSM states (IDLE waiting for start, SHIFT collecting bits).
package p2s_pkg;

  localparam int unsigned P2S_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/rx_bit_counter.sv
// Bit-position counter for the serial receiver.
//   clk_i   : rising-edge clock
//   rst_ni  : synchronous active-low reset, clears the count to 0
//   load1_i : load the count with 1 (bit 0 of a frame was just captured)
//   inc_i   : advance the count by one; saturates at WIDTH-1
//   count_o : current bit position
//   last_o  : count_o == WIDTH-1, the next captured bit completes the word
module rx_bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load1_i,
  input  logic                     inc_i,
  output logic [$clog2(WIDTH)-1:0] count_o,
  output logic                     last_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] count_d, count_q;

  assign last_o  = (count_q == CntLast);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (load1_i) begin
      count_d = CntOne;
    end else if (inc_i && !last_o) begin
      count_d = count_q + CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Receive-side deserializer: rebuilds an LSB-first serial stream into WIDTH-bit words and
// presents them on a valid/ready port backed by a single holding register.
//   clk_i       : rising-edge clock
//   rst_ni      : synchronous active-low reset
//   serial_in_i : serial data, LSB first
//   start_i     : high in the same cycle as bit 0 of a frame
//   out_data_o  : assembled word (bit 0 = first received bit)
//   out_valid_o : out_data_o holds an unconsumed word
//   out_ready_i : consumer accepts the word when out_valid_o && out_ready_i
//   busy_o      : frame in progress
//   frame_err_o : one-cycle pulse, frame aborted by an early start
//   overrun_o   : one-cycle pulse, completed word dropped because the holding register was full
module serial_to_parallel_rx
  import p2s_pkg::*;
#(
  parameter int unsigned WIDTH = P2S_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             serial_in_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             frame_err_o,
  output logic             overrun_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  rx_state_t        state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic             frame_err_d, frame_err_q;
  logic             overrun_d, overrun_q;

  logic             cnt_load1, cnt_inc, cnt_last;
  logic [CntW-1:0]  cnt;
  logic             complete;
  logic [WIDTH-1:0] word;

  rx_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load1_i (cnt_load1),
    .inc_i   (cnt_inc),
    .count_o (cnt),
    .last_o  (cnt_last)
  );

  // The final bit bypasses the shift register and lands directly in the holding register.
  assign word = {serial_in_i, shreg_q[WIDTH-2:0]};

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    cnt_load1   = 1'b0;
    cnt_inc     = 1'b0;
    complete    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          shreg_d[0] = serial_in_i;
          cnt_load1  = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (start_i) begin
          // Early start wins even on the completing bit: the old frame is discarded and this
          // cycle's bit begins the new one.
          frame_err_d = 1'b1;
          shreg_d[0]  = serial_in_i;
          cnt_load1   = 1'b1;
        end else begin
          shreg_d[cnt] = serial_in_i;
          if (cnt_last) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      if (!valid_q || out_ready_i) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;
  assign busy_o      = (state_q == SHIFT);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a queue-based frame model.
module tb_serial_to_parallel_rx;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         serial_in = 1'b0;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_to_parallel_rx #(
    .WIDTH (W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .serial_in_i (serial_in),
    .start_i     (start),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of received bits; a word exists once W bits are in.
  bit           mdl_ok = 1'b0;
  bit           m_collect;
  int           m_bits[$];
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_ferr;
  bit           m_ovr;

  always @(posedge clk) begin
    bit          done;
    logic [W-1:0] w;
    done = 1'b0;
    w    = '0;
    if (!rst_n) begin
      mdl_ok    = 1'b1;
      m_collect = 1'b0;
      m_bits.delete();
      m_valid   = 1'b0;
      m_data    = '0;
      m_ferr    = 1'b0;
      m_ovr     = 1'b0;
    end else begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (start) begin
        if (m_collect) m_ferr = 1'b1;
        m_bits.delete();
        m_bits.push_back(int'(serial_in));
        m_collect = 1'b1;
      end else if (m_collect) begin
        m_bits.push_back(int'(serial_in));
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) w = w + (W'(m_bits[i]) << i);
          done      = 1'b1;
          m_collect = 1'b0;
          m_bits.delete();
        end
      end
      if (done) begin
        if (!m_valid || out_ready) begin
          m_data  = w;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  int ferr_seen = 0;
  int ovr_seen = 0;

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("busy", 32'(busy), 32'(m_collect));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("overrun", 32'(overrun), 32'(m_ovr));
    end
    if (frame_err === 1'b1) ferr_seen++;
    if (overrun === 1'b1) ovr_seen++;
  end

  task automatic drive(input logic s, input logic st, input logic rdy);
    serial_in = s;
    start     = st;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input logic rdy);
    for (int i = 0; i < W; i++) drive(w[i], i == 0, rdy);
  endtask

  initial begin
    logic [W-1:0] pat;
    int           f0, o0, busy_cycles;

    // Reset
    rst_n = 1'b0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    drive(0, 0, 1);

    // Single frame 0xA5 (bits 1,0,1,0,0,1,0,1)
    busy_cycles = 0;
    for (int i = 0; i < W; i++) begin
      pat = 8'hA5;
      drive(pat[i], i == 0, 1);
      if (busy === 1'b1) busy_cycles++;
      if (i < W - 1) chk("a5_valid_early", 32'(out_valid), 32'd0);
    end
    chk("a5_valid", 32'(out_valid), 32'd1);
    chk("a5_data", 32'(out_data), 32'hA5);
    chk("a5_busy_cycles", 32'(busy_cycles), 32'd7);
    drive(0, 0, 1);
    chk("a5_valid_one_cycle", 32'(out_valid), 32'd0);

    // Back-to-back 0x3C, 0xFF
    f0 = ferr_seen; o0 = ovr_seen;
    send(8'h3C, 1);
    chk("b2b_first", 32'(out_data), 32'h3C);
    send(8'hFF, 1);
    chk("b2b_second", 32'(out_data), 32'hFF);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    drive(0, 0, 1);
    chk("b2b_no_ovr", 32'(ovr_seen - o0), 32'd0);
    chk("b2b_no_ferr", 32'(ferr_seen - f0), 32'd0);

    // Backpressure: 0x11 held, 0x22 dropped
    o0 = ovr_seen;
    send(8'h11, 0);
    send(8'h22, 0);
    chk("bp_data", 32'(out_data), 32'h11);
    chk("bp_valid", 32'(out_valid), 32'd1);
    drive(0, 0, 1);
    chk("bp_ovr_once", 32'(ovr_seen - o0), 32'd1);
    chk("bp_consumed", 32'(out_valid), 32'd0);

    // Consume and load on the same edge
    o0 = ovr_seen;
    send(8'h11, 0);
    pat = 8'h5A;
    for (int i = 0; i < W; i++) drive(pat[i], i == 0, i == W - 1);
    chk("cl_valid", 32'(out_valid), 32'd1);
    chk("cl_data", 32'(out_data), 32'h5A);
    drive(0, 0, 1);
    chk("cl_no_ovr", 32'(ovr_seen - o0), 32'd0);

    // Early start at bit 4, then 0xC3
    f0 = ferr_seen;
    for (int i = 0; i < 4; i++) drive(1, i == 0, 1);
    send(8'hC3, 1);
    chk("fe_data", 32'(out_data), 32'hC3);
    chk("fe_valid", 32'(out_valid), 32'd1);
    drive(0, 0, 1);
    chk("fe_once", 32'(ferr_seen - f0), 32'd1);

    // Reset mid-frame with a pending word
    send(8'h77, 0);
    for (int i = 0; i < 3; i++) drive(1, i == 0, 0);
    rst_n = 1'b0;
    drive(1, 0, 0);
    rst_n = 1'b1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_data", 32'(out_data), 32'd0);
    send(8'h96, 1);
    chk("mr_after_data", 32'(out_data), 32'h96);
    chk("mr_after_valid", 32'(out_valid), 32'd1);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0,
            $urandom_range(0, 3) != 0);
    end
    rst_n = 1'b1;
    drive(0, 0, 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
